// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access controller: single-cycle word stores, read-modify-write
// sub-word stores and one-wait-state loads against a synchronous-read word memory.
//
// state   | meaning
// IDLE    | accept request; word store writes immediately
// RMW_RD  | read data returning; merge store lane into word
// RMW_WR  | write merged word back
// LD_WAIT | read data returning; register it for the load path
module dmem_rmw_ctrl #(
  parameter int          DMEM_AW    = 10,
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MemWriteM,
  input  logic               MemReadM,
  input  logic [4:0]         MemSrcM,
  input  logic [31:0]        AddrM,
  input  logic [31:0]        StoreDataM,
  input  logic [31:0]        dmem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic [31:0]        dmem_wdata,
  output logic [31:0]        ReadWordM,
  output logic               LoadValidM,
  output logic               StallM,
  output logic               MisalignM
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR, LD_WAIT} state_t;

  state_t      state;
  logic [31:0] merge_q;
  logic [31:0] merged;

  logic onehot, is_half, is_word;
  logic st_byte, st_half, st_word, st_ok, ld_ok, misal;
  logic in_idle, word_st, sub_st, load_go;
  logic unused_addr;

  // Size bits: [4]=membM [3]=memhM [2]=lwM [1]=membuM [0]=memhuM
  assign onehot  = (MemSrcM != 5'd0) && ((MemSrcM & (MemSrcM - 5'd1)) == 5'd0);
  assign is_half = onehot & (MemSrcM[3] | MemSrcM[0]);
  assign is_word = onehot & MemSrcM[2];

  // Unsigned size codes have no meaning for stores and decode to no access.
  assign st_byte = MemWriteM & onehot & MemSrcM[4];
  assign st_half = MemWriteM & onehot & MemSrcM[3];
  assign st_word = MemWriteM & onehot & MemSrcM[2];
  assign st_ok   = st_byte | st_half | st_word;
  assign ld_ok   = ~MemWriteM & MemReadM & onehot;
  assign misal   = (is_half & AddrM[0]) | (is_word & (AddrM[1:0] != 2'b00));

  // Strobes are gated by reset so nothing reaches memory while rst_n is low.
  assign in_idle = rst_n && (state == IDLE);
  assign word_st = in_idle & st_word & ~misal;
  assign sub_st  = in_idle & (st_byte | st_half) & ~misal;
  assign load_go = in_idle & ld_ok & ~misal;

  assign MisalignM  = in_idle & (st_ok | ld_ok) & misal;
  assign dmem_re    = sub_st | load_go;
  assign dmem_we    = word_st | (rst_n && (state == RMW_WR));
  assign StallM     = sub_st | load_go | (rst_n && (state == RMW_RD));
  assign dmem_wdata = word_st ? StoreDataM : merge_q;
  assign dmem_addr  = rst_n ? AddrM[DMEM_AW+1:2] : '0;

  assign unused_addr = ^AddrM[31:DMEM_AW+2];

  always_comb begin
    merged = dmem_rdata;
    if (MemSrcM[4])
      merged[{AddrM[1:0], 3'b000} +: 8] = StoreDataM[7:0];
    else if (MemSrcM[3])
      merged[{AddrM[1], 4'b0000} +: 16] = StoreDataM[15:0];
  end

  // Load data is registered, so ReadWordM/LoadValidM appear the cycle after LD_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      merge_q    <= RESET_DATA;
      ReadWordM  <= RESET_DATA;
      LoadValidM <= 1'b0;
    end else begin
      LoadValidM <= 1'b0;
      case (state)
        IDLE: begin
          if (sub_st)
            state <= RMW_RD;
          else if (load_go)
            state <= LD_WAIT;
        end
        RMW_RD: begin
          merge_q <= merged;
          state   <= RMW_WR;
        end
        RMW_WR: state <= IDLE;
        LD_WAIT: begin
          ReadWordM  <= dmem_rdata;
          LoadValidM <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: table of single-cycle request vectors plus
// hand-written RMW, load, store-to-load and reset-abort sequences.
module tb_dmem_rmw_ctrl;

  localparam logic [4:0] SB = 5'b10000, SH = 5'b01000, SW = 5'b00100,
                         SBU = 5'b00010, SHU = 5'b00001;

  logic        clk, rst_n;
  logic        MemWriteM, MemReadM;
  logic [4:0]  MemSrcM;
  logic [31:0] AddrM, StoreDataM, dmem_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_re, dmem_we;
  logic [31:0] dmem_wdata, ReadWordM;
  logic        LoadValidM, StallM, MisalignM;

  int n_chk = 0;
  int n_err = 0;

  dmem_rmw_ctrl dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .MemSrcM(MemSrcM), .AddrM(AddrM), .StoreDataM(StoreDataM),
    .dmem_rdata(dmem_rdata), .dmem_addr(dmem_addr), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .ReadWordM(ReadWordM),
    .LoadValidM(LoadValidM), .StallM(StallM), .MisalignM(MisalignM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory model with a bench-side preload port.
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  int          we_cnt = 0;
  int          both_cnt = 0;

  always @(posedge clk) begin
    if (dmem_re) dmem_rdata <= mem[dmem_addr];
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (dmem_we) we_cnt <= we_cnt + 1;
    if (dmem_we && dmem_re) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    MemWriteM = 1'b0; MemReadM = 1'b0; MemSrcM = 5'd0;
    AddrM = 32'h0; StoreDataM = 32'h0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the write-back edge with
  // the request still driven so the caller can chain the next request.
  task automatic run_sub(input string name, input logic [4:0] src, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_word);
    logic [31:0] aa;
    aa = a;
    MemWriteM = 1'b1; MemReadM = 1'b0; MemSrcM = src; AddrM = a; StoreDataM = d;
    #1 chk({name, " c1 re/we/stall"}, {29'd0, dmem_re, dmem_we, StallM}, 32'b101);
    @(posedge clk); @(negedge clk);
    #1 chk({name, " c2 re/we/stall"}, {29'd0, dmem_re, dmem_we, StallM}, 32'b001);
    @(posedge clk); @(negedge clk);
    #1 chk({name, " c3 re/we/stall"}, {29'd0, dmem_re, dmem_we, StallM}, 32'b010);
    chk({name, " wdata"}, dmem_wdata, exp_word);
    chk({name, " addr"}, {22'd0, dmem_addr}, {22'd0, aa[11:2]});
    @(posedge clk); @(negedge clk);
    chk({name, " mem"}, mem[aa[11:2]], exp_word);
  endtask

  task automatic run_load(input string name, input logic [4:0] src, input logic [31:0] a,
                          input logic [31:0] exp_word);
    MemWriteM = 1'b0; MemReadM = 1'b1; MemSrcM = src; AddrM = a; StoreDataM = 32'h0;
    #1 chk({name, " c1 re/we/stall/mis"}, {28'd0, dmem_re, dmem_we, StallM, MisalignM}, 32'b1010);
    @(posedge clk); @(negedge clk);
    #1 chk({name, " wait re/we/stall"}, {29'd0, dmem_re, dmem_we, StallM}, 32'b000);
    @(posedge clk); @(negedge clk);
    set_idle();
    #1 chk({name, " valid"}, {31'd0, LoadValidM}, 32'd1);
    chk({name, " word"}, ReadWordM, exp_word);
    @(posedge clk); @(negedge clk);
    #1 chk({name, " valid pulse end"}, {31'd0, LoadValidM}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [4:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  exp;   // {dmem_we, dmem_re, StallM, MisalignM}
  } vec_t;

  vec_t tv [15];
  int   wc;

  initial begin
    tv[0]  = '{"idle",           1'b0, 1'b0, SW,       32'h40, 32'h0,         4'b0000};
    tv[1]  = '{"sw 40",          1'b1, 1'b0, SW,       32'h40, 32'h1234_5678, 4'b1000};
    tv[2]  = '{"sw 44",          1'b1, 1'b0, SW,       32'h44, 32'hCAFE_F00D, 4'b1000};
    tv[3]  = '{"sw+rd 4c",       1'b1, 1'b1, SW,       32'h4C, 32'h0F0F_0F0F, 4'b1000};
    tv[4]  = '{"sh 41 misal",    1'b1, 1'b0, SH,       32'h41, 32'h1122,      4'b0001};
    tv[5]  = '{"lw 42 misal",    1'b0, 1'b1, SW,       32'h42, 32'h0,         4'b0001};
    tv[6]  = '{"sw 43 misal",    1'b1, 1'b0, SW,       32'h43, 32'h9999_9999, 4'b0001};
    tv[7]  = '{"store bu",       1'b1, 1'b0, SBU,      32'h40, 32'hFF,        4'b0000};
    tv[8]  = '{"store 2hot",     1'b1, 1'b0, 5'b10100, 32'h40, 32'hFF,        4'b0000};
    tv[9]  = '{"store nosize",   1'b1, 1'b0, 5'b00000, 32'h40, 32'hFF,        4'b0000};
    tv[10] = '{"load nosize",    1'b0, 1'b1, 5'b00000, 32'h40, 32'h0,         4'b0000};
    tv[11] = '{"store hu 41",    1'b1, 1'b0, SHU,      32'h41, 32'hFF,        4'b0000};
    tv[12] = '{"lhu 41 misal",   1'b0, 1'b1, SHU,      32'h41, 32'h0,         4'b0001};
    tv[13] = '{"sh 43 misal",    1'b1, 1'b0, SH,       32'h43, 32'h3344,      4'b0001};
    tv[14] = '{"load 2hot",      1'b0, 1'b1, 5'b00011, 32'h40, 32'h0,         4'b0000};

    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk("reset strobes", {27'd0, dmem_we, dmem_re, StallM, MisalignM, LoadValidM}, 32'd0);
    chk("reset wdata", dmem_wdata, 32'h0);
    chk("reset rword", ReadWordM, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    preload(10'h010, 32'hAAAA_AAAA);
    preload(10'h013, 32'h5555_5555);
    for (int i = 0; i < 15; i++) begin
      logic [31:0] a;
      MemWriteM = tv[i].we; MemReadM = tv[i].re; MemSrcM = tv[i].src;
      AddrM = tv[i].addr; StoreDataM = tv[i].data;
      a = tv[i].addr;
      #1 chk(tv[i].name, {28'd0, dmem_we, dmem_re, StallM, MisalignM}, {28'd0, tv[i].exp});
      if (tv[i].exp[3]) begin
        chk({tv[i].name, " wdata"}, dmem_wdata, tv[i].data);
        chk({tv[i].name, " addr"}, {22'd0, dmem_addr}, {22'd0, a[11:2]});
      end
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
    chk("mem 0x40 after sw", mem[10'h010], 32'h1234_5678);
    chk("mem 0x44 after sw", mem[10'h011], 32'hCAFE_F00D);
    chk("mem 0x4c write prio", mem[10'h013], 32'h0F0F_0F0F);

    preload(10'h010, 32'hAABB_CCDD);
    run_sub("sb 42", SB, 32'h42, 32'h0000_00EE, 32'hAAEE_CCDD);
    set_idle();
    @(negedge clk);
    preload(10'h010, 32'hAABB_CCDD);
    run_sub("sh 40", SH, 32'h40, 32'h0000_1122, 32'hAABB_1122);
    set_idle();
    @(negedge clk);
    preload(10'h010, 32'hAABB_CCDD);
    run_sub("sh 42", SH, 32'h42, 32'h0000_1122, 32'h1122_CCDD);
    set_idle();
    @(negedge clk);

    // Store followed immediately by a load of the same word.
    preload(10'h010, 32'h1122_3344);
    run_sub("sb 43", SB, 32'h43, 32'hFFFF_FF5A, 32'h5A22_3344);
    run_load("lw 40 after sb", SW, 32'h40, 32'h5A22_3344);
    run_load("lbu 45", SBU, 32'h45, 32'hCAFE_F00D);

    // Reset during RMW_RD aborts the store without a write.
    preload(10'h012, 32'h0BAD_BEEF);
    MemWriteM = 1'b1; MemReadM = 1'b0; MemSrcM = SB; AddrM = 32'h48; StoreDataM = 32'h77;
    @(posedge clk); @(negedge clk);
    wc = we_cnt;
    #2 rst_n = 1'b0;
    #1 chk("rst mid strobes", {27'd0, dmem_we, dmem_re, StallM, MisalignM, LoadValidM}, 32'd0);
    chk("rst mid wdata", dmem_wdata, 32'h0);
    chk("rst mid rword", ReadWordM, 32'h0);
    chk("rst mid addr", {22'd0, dmem_addr}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst no write", we_cnt, wc);
    chk("rst mem kept", mem[10'h012], 32'h0BAD_BEEF);
    rst_n = 1'b1;
    MemSrcM = SW; StoreDataM = 32'h600D_F00D;
    #1 chk("post-rst sw strobes", {29'd0, dmem_we, dmem_re, StallM}, 32'b100);
    @(posedge clk); @(negedge clk);
    set_idle();
    chk("post-rst sw mem", mem[10'h012], 32'h600D_F00D);
    chk("we/re exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
